// File: rtl/audio_sfx_scheduler.sv
// Priority scheduler that shares one SFX player between NREQ requesters.
// The highest requester index wins; a higher priority preempts the sound already playing.
`ifndef SFXIDBITS
`define SFXIDBITS 4
`endif

module audio_sfx_scheduler #(
    parameter int NREQ       = 4,
    parameter int START_WAIT = 6,
    parameter int IDXW       = $clog2(NREQ)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ*`SFXIDBITS-1:0]    req_id,
    input  logic                          mute,
    input  logic                          pause_in,
    input  logic                          sfxplaying,
    output logic [`SFXIDBITS-1:0]         newsfxid,
    output logic                          grabnewsfxid,
    output logic                          stop,
    output logic                          pause,
    output logic                          busy,
    output logic [IDXW-1:0]               cur_idx
);

    localparam int SW = `SFXIDBITS;
    localparam int TW = $clog2(START_WAIT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(START_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAITSTART = 2'd1,
        ST_PLAYING   = 2'd2
    } state_t;

    state_t                      state_r;
    state_t                      state_n_s;
    logic [TW-1:0]               timer_r;
    logic [TW-1:0]               timer_n_s;
    logic [NREQ-1:0]             pending_r;
    logic [NREQ-1:0][SW-1:0]     pend_id_r;
    logic [IDXW-1:0]             win_idx_s;
    logic                        any_pend_s;
    logic                        grant_ok_s;
    logic                        preempt_s;
    logic                        grant_s;

    logic [SW-1:0]               newsfxid_r;
    logic                        grab_r;
    logic                        stop_r;
    logic                        pause_r;
    logic                        busy_r;
    logic [IDXW-1:0]             cur_idx_r;

    // Pick the highest-index pending requester and decide whether a grant is allowed
    always_comb begin
        win_idx_s  = '0;
        any_pend_s = |pending_r;
        for (int i = 0; i < NREQ; i++) begin
            win_idx_s = pending_r[i] ? IDXW'(i) : win_idx_s;
        end
        grant_ok_s = any_pend_s & ~mute & ~pause_in;
        preempt_s  = grant_ok_s & (win_idx_s > cur_idx_r);
    end

    // Next-state, timer and grant decision
    always_comb begin
        state_n_s = state_r;
        timer_n_s = timer_r;
        grant_s   = 1'b0;
        if (mute) begin
            state_n_s = ST_IDLE;
            timer_n_s = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_ok_s) begin
                        grant_s   = 1'b1;
                        state_n_s = ST_WAITSTART;
                        timer_n_s = '0;
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end
                // sfxplaying may still belong to a preempted sound here, so it is not looked at
                ST_WAITSTART: begin
                    if (preempt_s) begin
                        grant_s   = 1'b1;
                        state_n_s = ST_WAITSTART;
                        timer_n_s = '0;
                    end else if (timer_r == TIMER_LAST) begin
                        state_n_s = ST_PLAYING;
                    end else begin
                        timer_n_s = timer_r + TW'(1);
                    end
                end
                ST_PLAYING: begin
                    if (preempt_s) begin
                        grant_s   = 1'b1;
                        state_n_s = ST_WAITSTART;
                        timer_n_s = '0;
                    end else if (!sfxplaying) begin
                        state_n_s = ST_IDLE;
                    end else begin
                        state_n_s = ST_PLAYING;
                    end
                end
                default: begin
                    state_n_s = ST_IDLE;
                    timer_n_s = '0;
                end
            endcase
        end
    end

    // State and timer registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            timer_r <= '0;
        end else begin
            state_r <= state_n_s;
            timer_r <= timer_n_s;
        end
    end

    // Per-requester latch; a fresh request beats a same-cycle grant of that requester
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_r <= '0;
            pend_id_r <= '0;
        end else if (mute) begin
            pending_r <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    pending_r[i] <= 1'b1;
                    pend_id_r[i] <= req_id[i*SW +: SW];
                end else if (grant_s && (win_idx_s == IDXW'(i))) begin
                    pending_r[i] <= 1'b0;
                end else begin
                    pending_r[i] <= pending_r[i];
                end
            end
        end
    end

    // Registered outputs towards the manager
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            newsfxid_r <= '0;
            grab_r     <= 1'b0;
            stop_r     <= 1'b0;
            pause_r    <= 1'b0;
            busy_r     <= 1'b0;
            cur_idx_r  <= '0;
        end else begin
            grab_r  <= grant_s;
            stop_r  <= mute;
            pause_r <= pause_in;
            busy_r  <= (state_n_s != ST_IDLE);
            if (grant_s) begin
                newsfxid_r <= pend_id_r[win_idx_s];
                cur_idx_r  <= win_idx_s;
            end else begin
                newsfxid_r <= newsfxid_r;
                cur_idx_r  <= cur_idx_r;
            end
        end
    end

    assign newsfxid     = newsfxid_r;
    assign grabnewsfxid = grab_r;
    assign stop         = stop_r;
    assign pause        = pause_r;
    assign busy         = busy_r;
    assign cur_idx      = cur_idx_r;

endmodule

// File: tb/tb_audio_sfx_scheduler.sv
// Directed bench for audio_sfx_scheduler: hand-computed grant timing, queueing,
// preemption, mute, pause and stop-code behaviour.
`ifndef SFXIDBITS
`define SFXIDBITS 4
`endif

module tb_audio_sfx_scheduler;

    localparam int NREQ = 4;
    localparam int SW   = `SFXIDBITS;
    localparam int IDXW = 2;

    logic                 clk;
    logic                 resetn;
    logic [NREQ-1:0]      req;
    logic [NREQ*SW-1:0]   req_id;
    logic                 mute;
    logic                 pause_in;
    logic                 sfxplaying;
    logic [SW-1:0]        newsfxid;
    logic                 grabnewsfxid;
    logic                 stop;
    logic                 pause;
    logic                 busy;
    logic [IDXW-1:0]      cur_idx;

    int tests_run;
    int tests_failed;
    int cyc;

    audio_sfx_scheduler #(.NREQ(NREQ), .START_WAIT(6)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req          (req),
        .req_id       (req_id),
        .mute         (mute),
        .pause_in     (pause_in),
        .sfxplaying   (sfxplaying),
        .newsfxid     (newsfxid),
        .grabnewsfxid (grabnewsfxid),
        .stop         (stop),
        .pause        (pause),
        .busy         (busy),
        .cur_idx      (cur_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run = tests_run + 1;
        assert (obs === exp) else begin
            tests_failed = tests_failed + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int idx, input logic [SW-1:0] id);
        req = '0;
        req[idx] = 1'b1;
        req_id[idx*SW +: SW] = id;
        tick();
        req = '0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        resetn       = 1'b0;
        req          = '0;
        req_id       = '0;
        mute         = 1'b0;
        pause_in     = 1'b0;
        sfxplaying   = 1'b0;
        #2;
        check("rst_grab", grabnewsfxid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_id",   newsfxid, 4'd0);
        check("rst_idx",  cur_idx, 2'd0);
        check("rst_stop", stop, 1'b0);
        check("rst_pause", pause, 1'b0);
        ticks(2);
        resetn = 1'b1;
        ticks(2);
        check("idle_busy", busy, 1'b0);

        // single request: grab at cycle 1, busy until cycle 42
        cyc = -1;
        pulse(1, 4'd7);
        check("t1_c0_grab", grabnewsfxid, 1'b0);
        tick();
        check("t1_c1_grab", grabnewsfxid, 1'b1);
        check("t1_c1_id",   newsfxid, 4'd7);
        check("t1_c1_busy", busy, 1'b1);
        check("t1_c1_idx",  cur_idx, 2'd1);
        tick();
        check("t1_c2_grab", grabnewsfxid, 1'b0);
        run_to(5);
        sfxplaying = 1'b1;
        run_to(41);
        check("t1_c41_busy", busy, 1'b1);
        sfxplaying = 1'b0;
        tick();
        check("t1_c42_busy", busy, 1'b0);
        ticks(2);

        // lower priority waits for the current sound to end
        pulse(2, 4'd3);
        tick();
        check("t2_grab", grabnewsfxid, 1'b1);
        check("t2_id",   newsfxid, 4'd3);
        sfxplaying = 1'b1;
        ticks(8);
        pulse(0, 4'd9);
        ticks(3);
        check("t2_wait_grab", grabnewsfxid, 1'b0);
        check("t2_wait_idx",  cur_idx, 2'd2);
        sfxplaying = 1'b0;
        tick();
        check("t2_idle_busy", busy, 1'b0);
        check("t2_idle_grab", grabnewsfxid, 1'b0);
        tick();
        check("t2_q_grab", grabnewsfxid, 1'b1);
        check("t2_q_id",   newsfxid, 4'd9);
        check("t2_q_idx",  cur_idx, 2'd0);
        // grabbed with sfxplaying low: stop-code path, idle 7 cycles after the grab
        ticks(6);
        check("t2_sc_busy6", busy, 1'b1);
        tick();
        check("t2_sc_busy7", busy, 1'b0);
        ticks(2);

        // preemption by a higher priority
        pulse(0, 4'd4);
        tick();
        check("t3_grab0", newsfxid, 4'd4);
        sfxplaying = 1'b1;
        ticks(8);
        pulse(3, 4'd12);
        check("t3_latch_grab", grabnewsfxid, 1'b0);
        tick();
        check("t3_pre_grab", grabnewsfxid, 1'b1);
        check("t3_pre_id",   newsfxid, 4'd12);
        check("t3_pre_idx",  cur_idx, 2'd3);
        ticks(8);
        sfxplaying = 1'b0;
        tick();
        check("t3_end_busy", busy, 1'b0);
        tick();
        check("t3_norequeue_grab", grabnewsfxid, 1'b0);
        check("t3_norequeue_busy", busy, 1'b0);
        ticks(2);

        // simultaneous requests, then a re-request overwriting the queued ID
        req = 4'b0110;
        req_id[1*SW +: SW] = 4'd5;
        req_id[2*SW +: SW] = 4'd6;
        tick();
        req = '0;
        tick();
        check("t4_first_id",  newsfxid, 4'd6);
        check("t4_first_idx", cur_idx, 2'd2);
        sfxplaying = 1'b1;
        ticks(2);
        pulse(1, 4'd8);
        ticks(8);
        check("t4_hold_grab", grabnewsfxid, 1'b0);
        sfxplaying = 1'b0;
        tick();
        tick();
        check("t4_second_grab", grabnewsfxid, 1'b1);
        check("t4_second_id",   newsfxid, 4'd8);
        check("t4_second_idx",  cur_idx, 2'd1);
        ticks(10);
        check("t4_done_busy", busy, 1'b0);

        // mute while playing with a queued request
        pulse(2, 4'd2);
        tick();
        sfxplaying = 1'b1;
        ticks(8);
        pulse(0, 4'd1);
        mute = 1'b1;
        tick();
        check("t5_stop",  stop, 1'b1);
        check("t5_busy",  busy, 1'b0);
        check("t5_grab",  grabnewsfxid, 1'b0);
        check("t5_idx",   cur_idx, 2'd2);
        mute = 1'b0;
        sfxplaying = 1'b0;
        tick();
        check("t5_unstop", stop, 1'b0);
        ticks(2);
        check("t5_flush_grab", grabnewsfxid, 1'b0);
        check("t5_flush_busy", busy, 1'b0);

        // pause inhibits the grant; release grants a stop-code ID
        pause_in = 1'b1;
        pulse(1, 4'd10);
        check("t6_pause", pause, 1'b1);
        ticks(3);
        check("t6_hold_grab", grabnewsfxid, 1'b0);
        check("t6_hold_busy", busy, 1'b0);
        pause_in = 1'b0;
        tick();
        check("t6_unpause", pause, 1'b0);
        check("t6_grab", grabnewsfxid, 1'b1);
        check("t6_id",   newsfxid, 4'd10);
        ticks(6);
        check("t6_sc_busy6", busy, 1'b1);
        tick();
        check("t6_sc_busy7", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/audio_sfx_scheduler.md
Name: audio_sfx_scheduler

Overview:
- Priority scheduler in front of audio_sfx_manager. Shares the single SFX player between NREQ game-event requesters.
- Latches one pending SFX ID per requester and grants the highest-priority pending request.
- Drives the manager's newsfxid/grabnewsfxid/stop/pause, and tracks completion via sfxplaying.
- Higher priority preempts a lower-priority sound already playing. Lower or equal priority requests wait.

Parameters:
- NREQ, 4: number of requesters. Requester index = priority; a higher index is a higher priority.
- START_WAIT, 6: cycles after a grant before sfxplaying is trusted. Minimum 5, to cover the manager's load path.
- IDXW, $clog2(NREQ): derived width of the requester index. Not overridden by users.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req  in  NREQ  one-cycle request pulse per requester
- req_id  in  NREQ*`SFXIDBITS  SFX ID per requester; slot i = [i*`SFXIDBITS +: `SFXIDBITS]
- mute  in  1  level; silence the player and flush all pending requests
- pause_in  in  1  level; pause the player
- sfxplaying  in  1  from the manager
- newsfxid  out  `SFXIDBITS  to the manager
- grabnewsfxid  out  1  to the manager; single-cycle pulse
- stop  out  1  to the manager
- pause  out  1  to the manager
- busy  out  1  state != IDLE
- cur_idx  out  IDXW  requester currently owning the player

Behaviour:
- Reset (async, resetn=0): all outputs 0, pending[] = 0, pend_id[] = 0, state = IDLE, timer = 0.
- All outputs are registered. stop <= mute and pause <= pause_in, one cycle of latency each.

Request latch, per requester i:
- On req[i] with mute=0: pending[i] <= 1, pend_id[i] <= req_id slot i. A repeat request overwrites the ID.
- A grant of i clears pending[i]. If req[i] arrives in the same cycle as the grant of i, the request wins: pending stays 1 with the new ID.
- mute=1: every pending[] cleared, req ignored.

Selection:
- w = highest index with pending=1.
- A grant is legal when any pending bit is set, mute=0 and pause_in=0.

Grant action (one edge):
- grabnewsfxid <= 1, newsfxid <= pend_id[w], cur_idx <= w, pending[w] <= 0, timer <= 0, state <= WAITSTART.
- grabnewsfxid returns to 0 on the next edge unless another grant occurs.

State machine:
- IDLE: grant if legal.
- WAITSTART: timer increments each cycle.
  - If a grant is legal with w > cur_idx, preempt: regrant, timer restarts at 0.
  - Else when timer == START_WAIT-1, go to PLAYING.
  - sfxplaying is ignored in this state, because it may still be high from the preempted sound.
- PLAYING:
  - Preemption as in WAITSTART.
  - Else if sfxplaying == 0, go to IDLE, and a grant from IDLE is possible on the next edge.
  - A looping SFX holds PLAYING indefinitely; lower-priority requests stay pending.
- Any state with mute=1: go to IDLE on the next edge, grabnewsfxid forced 0, cur_idx held.
- pause_in=1:
  - Grants and preemption are inhibited; pending requests still accumulate.
  - The WAITSTART timer keeps running.
  - The PLAYING end-detect stays active, since the manager keeps sfxplaying=1 while paused.
- Equal priority never preempts: a re-request by cur_idx waits until the current sound ends.
- Stop-code SFX (no sound played): sfxplaying is 0 at PLAYING entry, so the block returns to IDLE one cycle later.

Test Plan:
- Single request: req[1] with ID 7 at cycle 0 -> grab=1 with newsfxid=7 at cycle 1 only, busy=1, cur_idx=1. Model sfxplaying high from cycle 6 to 40 -> PLAYING then IDLE, busy=0 at cycle 42.
- Queued lower priority: req[2] with ID 3 playing, then req[0] with ID 9 -> no grab until sfxplaying falls. Next cycle after IDLE: grab with newsfxid=9.
- Preemption: req[0] with ID 4 playing, then req[3] with ID 12 -> grab with 12 the next cycle, cur_idx=3. Requester 0 not re-queued; pending[0]=0.
- Simultaneous: req[1] with ID 5 and req[2] with ID 6 in the same cycle -> grant 6 first, then 5 after completion. Re-request of req[1] with ID 8 before completion -> 8 is played, not 5.
- Mute mid-play: mute=1 during PLAYING with pending[0] set -> stop=1 next cycle, IDLE, pending cleared. After mute=0 -> no grab.
- Pause and stop code: pause_in=1 with req[1] pending -> no grab, pause=1. Release -> grab. If the grabbed ID is a stop code (sfxplaying 0) -> IDLE at START_WAIT+1 cycles after the grab.
